// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding a 2-entry {pc, inst} buffer toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ce,
  output logic [31:0] addr,
  input  logic [31:0] inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        fault,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, HALTED, FAULT} state_t;
  state_t state, state_nx;
  logic [31:0] pc;
  logic [1:0] count;
  logic head;
  logic [31:0] pc_q [2];
  logic [31:0] inst_q [2];
  logic push, pop, tail;
  assign ce = state == FETCH && count < 2'd2 && !redirect_valid;
  assign push = ce;
  assign pop = out_valid && out_ready && !redirect_valid;
  assign tail = head ^ count[0];
  assign addr = pc;
  assign out_valid = count != 2'd0;
  assign out_pc = pc_q[head];
  assign out_inst = inst_q[head];
  assign fault = state == FAULT;
  // Redirect outranks halt; only reset leaves FAULT.
  always_comb begin
    state_nx = redirect_valid ? ((state == FAULT || |redirect_pc[1:0]) ? FAULT : FETCH)
             : state == FAULT ? FAULT
             : (halt && state != IDLE) ? HALTED : FETCH;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      count <= 2'd0;
      head <= 1'b0;
      fetch_count <= 32'd0;
      pc_q[0] <= 32'd0;
      pc_q[1] <= 32'd0;
      inst_q[0] <= 32'd0;
      inst_q[1] <= 32'd0;
    end else begin
      state <= state_nx;
      if (redirect_valid) begin
        pc <= redirect_pc;
        count <= 2'd0;
        head <= 1'b0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        if (pop) head <= ~head;
        if (push) begin
          pc <= pc + 32'd4;
          fetch_count <= fetch_count + 32'd1;
          pc_q[tail] <= pc;
          inst_q[tail] <= inst;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors against fetch_unit with a combinational ROM model.
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, redirect_valid = 1'b0, halt = 1'b0, out_ready = 1'b1;
  logic [31:0] redirect_pc = 32'd0;
  logic ce, out_valid, fault;
  logic [31:0] addr, inst, out_pc, out_inst, fetch_count;
  int vectors = 0, miscompares = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .ce(ce), .addr(addr), .inst(inst), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .fault(fault),
    .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  assign inst = 32'h1000_0000 + {24'd0, addr[9:2]};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_ce"}, {31'd0, ce}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_inst"}, out_inst, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_cnt"}, fetch_count, 32'd0);
  endtask
  initial begin
    step(2);
    chk_reset("rst0");
    rst = 1'b0;
    chk("idle_ce", {31'd0, ce}, 32'd0);
    step();
    chk("fetch_ce", {31'd0, ce}, 32'd1);
    chk("fetch_addr", addr, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("seq_valid", {31'd0, out_valid}, 32'd1);
      chk("seq_pc", out_pc, 32'(4 * k));
      chk("seq_inst", out_inst, 32'h1000_0000 + 32'(k));
    end
    chk("seq_cnt", fetch_count, 32'd3);
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    step(5);
    chk("stall_pc", out_pc, 32'd0);
    chk("stall_ce", {31'd0, ce}, 32'd0);
    chk("stall_addr", addr, 32'd8);
    chk("stall_cnt", fetch_count, 32'd2);
    out_ready = 1'b1;
    step();
    chk("drain_pc4", out_pc, 32'd4);
    chk("drain_inst4", out_inst, 32'h1000_0001);
    step();
    chk("drain_pc8", out_pc, 32'd8);
    chk("drain_inst8", out_inst, 32'h1000_0002);
    chk("drain_cnt", fetch_count, 32'd3);
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("redir_ce", {31'd0, ce}, 32'd0);
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_addr", addr, 32'h40);
    chk("flush_cnt", fetch_count, 32'd4);
    step();
    chk("redir_pc40", out_pc, 32'h40);
    chk("redir_inst40", out_inst, 32'h1000_0010);
    step();
    chk("redir_pc44", out_pc, 32'h44);
    chk("redir_cnt", fetch_count, 32'd6);
    halt = 1'b1;
    step();
    chk("halt_ce", {31'd0, ce}, 32'd0);
    chk("halt_pc48", out_pc, 32'h48);
    chk("halt_addr", addr, 32'h4C);
    step(2);
    chk("halt_empty", {31'd0, out_valid}, 32'd0);
    chk("halt_addr2", addr, 32'h4C);
    chk("halt_ce2", {31'd0, ce}, 32'd0);
    halt = 1'b0;
    step();
    chk("resume_ce", {31'd0, ce}, 32'd1);
    chk("resume_addr", addr, 32'h4C);
    step();
    chk("resume_pc", out_pc, 32'h4C);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr0", addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", addr, 32'd0);
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", out_inst, 32'h1000_00FF);
    out_ready = 1'b0;
    step();
    chk("wrap_full_addr", addr, 32'd4);
    #2 rst = 1'b1;
    #1;
    chk_reset("arst");
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_ce", {31'd0, ce}, 32'd0);
    chk("fault_valid", {31'd0, out_valid}, 32'd0);
    step(3);
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    chk("fault_ce2", {31'd0, ce}, 32'd0);
    chk("fault_valid2", {31'd0, out_valid}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("fault_clr", {31'd0, fault}, 32'd0);
    chk("fault_clr_addr", addr, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; the polarity and synchronicity are fixed.
REQ-004 redirect_valid  input  1  branch/jump redirect request from execute.
REQ-005 redirect_pc  input  32  redirect target address.
REQ-006 halt  input  1  stop issuing new fetches.
REQ-007 ce  output  1  instruction ROM chip enable.
REQ-008 addr  output  32  instruction ROM byte address; word index is addr[9:2].
REQ-009 inst  input  32  ROM read data, combinationally valid in the same cycle as ce/addr.
REQ-010 out_valid  output  1  fetched instruction available to decode.
REQ-011 out_ready  input  1  decode accepts the instruction.
REQ-012 out_pc  output  32  address of the presented instruction.
REQ-013 out_inst  output  32  presented instruction word.
REQ-014 fault  output  1  misaligned redirect detected; sticky.
REQ-015 fetch_count  output  32  number of instructions pushed into the buffer.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, HALTED and FAULT; reset enters IDLE.
REQ-017 IDLE SHALL last exactly one cycle with ce=0, then go to FETCH.
REQ-018 The 2-entry FIFO SHALL hold {pc, inst} pairs; out_valid=(count!=0); out_pc/out_inst = head entry.
REQ-019 ce SHALL equal (state==FETCH) && (count<2) && !redirect_valid; addr SHALL always equal the internal pc register.
REQ-020 A push occurs when ce=1: {pc, inst} enters the FIFO tail, pc <= pc+4 (mod 2^32 wrap), and fetch_count increments (wrapping).
REQ-021 Full: when count==2 there is no push and pc holds; a pop in the same cycle does not enable a push in that cycle.
REQ-022 A pop occurs when out_valid && out_ready; a push and a pop in the same cycle leave count unchanged.
REQ-023 A redirect SHALL have priority over push, pop and halt: the FIFO is flushed (count=0), pc <= redirect_pc, and nothing is pushed or popped.
REQ-024 After a redirect with redirect_pc[1:0]==0, the next state SHALL be FETCH from any non-FAULT state.
REQ-025 After a redirect with redirect_pc[1:0]!=0, the next state SHALL be FAULT, with fault=1.
REQ-026 In FAULT: ce=0, FIFO empty, fault=1; only rst exits FAULT.
REQ-027 halt=1 in FETCH (with no redirect) SHALL move to HALTED; that cycle still pushes if ce=1.
REQ-028 In HALTED: ce=0, pc holds, the FIFO keeps draining to decode, and halt deassertion returns to FETCH.
REQ-029 Latency: an instruction is pushed in the cycle ce=1 and appears at out_* on the next cycle.
REQ-030 With out_ready held at 1, the sustained throughput SHALL be one instruction per cycle.
REQ-031 out_pc/out_inst SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-032 While rst is asserted, outputs SHALL be: pc=RESET_PC, addr=RESET_PC, ce=0, count=0, out_valid=0, out_pc=0, out_inst=0, fault=0, fetch_count=0, state=IDLE.
REQ-033 rst asserted mid-operation SHALL clear the FIFO immediately without waiting for a clock edge; a push that is in flight is discarded.

Verification
REQ-034 Reset release, out_ready=1, ROM word k=32'h1000_0000+k -> ce first high on cycle 2; out_pc sequence is 0,4,8 on consecutive cycles with out_inst 1000_0000,1000_0001,1000_0002.
REQ-035 out_ready=0 for 5 cycles -> exactly 2 entries (pc 0,4) buffered, ce=0, addr=8 held; releasing out_ready drains 0,4 and then fetches 8 with no loss or duplication.
REQ-036 Redirect to 32'h0000_0040 while the FIFO holds 2 entries -> next cycle out_valid=0, then out_pc=0x40 and 0x44; fetch_count does not count the flushed cycle.
REQ-037 Redirect to 32'h0000_0042 -> fault=1, ce=0, out_valid=0 indefinitely, and rst clears it.
REQ-038 halt=1 with 1 entry buffered -> the entry drains, ce stays 0, addr frozen; halt=0 resumes at the frozen addr.
REQ-039 pc=32'hFFFF_FFFC after redirect -> the next addr is 32'h0000_0000 and rst pulsed asynchronously mid-stall returns all outputs to REQ-032 values before the next edge.
